// File: rtl/dlx_data_mem.sv
// dlx_data_mem: byte-addressed SDLX data memory with valid/ready requests, wait states and error reporting; define DMEM_CLEAR_EN to zero the array after reset
module dlx_data_mem #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;
  state_t state, next_state;
  logic [31:0] mem [DEPTH];
  logic [7:0] wait_cnt;
  logic a_we, a_signed;
  logic [1:0] a_size;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0] a_wdata;
  logic accept, finish, err;
  logic [IW-1:0] idx;
  logic [31:0] rd, ld, wd;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [3:0] be;
`ifdef DMEM_CLEAR_EN
  logic [IW-1:0] clr_idx;
`endif
  // next state and handshake qualifiers
  always_comb begin
    accept = state == IDLE && req_valid && req_ready;
    finish = state == BUSY && wait_cnt == 8'd0;
    next_state = accept ? BUSY : finish ? IDLE : state;
`ifdef DMEM_CLEAR_EN
    if (state == CLEAR && clr_idx == IW'(DEPTH - 1)) next_state = IDLE;
`endif
  end
  // decode the captured request: error checks, load extraction and store lane merge
  always_comb begin
    idx = a_addr[IW+1:2];
    rd = mem[idx];
    err = a_size == 2'b11 || (a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00) ||
          {2'b00, a_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH);
    rb = 8'(rd >> {a_addr[1:0], 3'b000});
    rh = a_addr[1] ? rd[31:16] : rd[15:0];
    ld = a_size == 2'b00 ? {{24{a_signed & rb[7]}}, rb} : a_size == 2'b01 ? {{16{a_signed & rh[15]}}, rh} : rd;
    be = a_size == 2'b00 ? 4'b0001 << a_addr[1:0] : a_size == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = a_size == 2'b00 ? {4{a_wdata[7:0]}} : a_size == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
  end
  // control state, wait counter, captured request and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_CLEAR_EN
      state <= CLEAR;
      clr_idx <= '0;
`else
      state <= IDLE;
`endif
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      req_ready <= next_state == IDLE;
      rsp_valid <= finish;
      rsp_err <= finish && err;
      rsp_rdata <= finish && !err && !a_we ? ld : '0;
      wait_cnt <= accept ? 8'(WAIT_CYCLES) : state == BUSY && wait_cnt != 8'd0 ? wait_cnt - 8'd1 : wait_cnt;
`ifdef DMEM_CLEAR_EN
      clr_idx <= state == CLEAR ? clr_idx + IW'(1) : clr_idx;
`endif
      if (accept) begin
        a_we <= req_we;
        a_size <= req_size;
        a_signed <= req_signed;
        a_addr <= req_addr;
        a_wdata <= req_wdata;
      end
    end
  end
  // array writes: post-reset clearing and lane-masked stores; no reset so contents survive it
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (!reset && state == CLEAR) mem[clr_idx] <= '0;
`endif
    if (!reset && finish && a_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dlx_data_mem.sv
// tb_dlx_data_mem: scoreboard bench for dlx_data_mem (DEPTH=256, WAIT_CYCLES=3), honours DMEM_CLEAR_EN
module tb_dlx_data_mem;
  localparam int WC = 3;
  localparam int DEPTH = 256;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {
    logic we;
    logic [1:0] sz;
    logic sg;
    logic [31:0] a;
    logic [31:0] wd;
    int at;
  } req_t;
  req_t sb[$];
  logic [31:0] mm [DEPTH];
  bit kn [DEPTH];

  dlx_data_mem #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = '0;
      kn[i] = 1;
    end
`endif
  endtask

  // pop the oldest outstanding request on each response, predict it from the model, then apply stores
  always @(negedge clk) begin : mon
    req_t r;
    logic [31:0] v, d;
    logic e;
    int w;
    if (rsp_valid) begin
      if (sb.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
      else begin
        r = sb.pop_front();
        w = int'(r.a >> 2);
        e = r.sz == 2'd3 || (r.sz == 2'd1 && r.a[0]) || (r.sz == 2'd2 && r.a[1:0] != 2'd0) || r.a >= 32'h400;
        d = 0;
        v = 0;
        if (!e) v = mm[w];
        if (!e && !r.we)
          case (r.sz)
            2'd0: begin d = (v >> (8 * r.a[1:0])) & 32'hFF; if (r.sg && d[7]) d = d | 32'hFFFFFF00; end
            2'd1: begin d = (v >> (16 * r.a[1])) & 32'hFFFF; if (r.sg && d[15]) d = d | 32'hFFFF0000; end
            default: d = v;
          endcase
        check($sformatf("rsp_cycle@%h", r.a), cyc, r.at);
        check($sformatf("rsp_err@%h", r.a), 32'(rsp_err), 32'(e));
        if (r.we || e || kn[w]) check($sformatf("rsp_rdata@%h", r.a), rsp_rdata, d);
        if (!e && r.we)
          case (r.sz)
            2'd0: mm[w][8 * r.a[1:0] +: 8] = r.wd[7:0];
            2'd1: mm[w][16 * r.a[1] +: 16] = r.wd[15:0];
            default: begin mm[w] = r.wd; kn[w] = 1; end
          endcase
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, output int acc);
    int n = 0;
    acc = -1;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    check("ready_timeout", 32'(n < 1000), 32'd1);
    if (n < 1000) begin
      acc = cyc + 1;
      sb.push_back('{we, sz, sg, a, wd, acc + WC + 1});
    end
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int t;
    send(we, sz, sg, a, wd, t);
    drain();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, a0, a1;
    reset = 1;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    reset = 0;
    wait_ready(n);
`ifdef DMEM_CLEAR_EN
    check("ready_low_cycles", n, DEPTH);
`else
    check("ready_low_cycles", n, 1);
`endif
    op(0, 2'd2, 0, 32'h40, 0);
    op(1, 2'd2, 0, 32'h8, 32'hDEADBEEF);
    op(0, 2'd2, 0, 32'h8, 0);
    op(1, 2'd0, 0, 32'h9, 32'h80);
    op(0, 2'd0, 1, 32'h9, 0);
    op(0, 2'd0, 0, 32'h9, 0);
    op(0, 2'd2, 0, 32'h8, 0);
    op(0, 2'd1, 1, 32'hA, 0);
    op(0, 2'd1, 0, 32'hA, 0);
    op(0, 2'd2, 1, 32'h8, 0);
    op(1, 2'd2, 0, 32'h0, 32'h11223344);
    op(0, 2'd1, 1, 32'h3, 0);
    op(1, 2'd2, 0, 32'h400, 32'hFFFFFFFF);
    op(0, 2'd2, 0, 32'h0, 0);
    op(0, 2'd3, 0, 32'h0, 0);
    op(1, 2'd3, 0, 32'h4, 32'h5A5A5A5A);
    op(0, 2'd2, 0, 32'h2, 0);
    op(1, 2'd1, 0, 32'h1, 32'hBEEF);
    op(1, 2'd2, 0, 32'h3FC, 32'h87654321);
    op(1, 2'd1, 0, 32'h3FE, 32'h0000ABCD);
    op(0, 2'd2, 0, 32'h3FC, 0);
    op(0, 2'd1, 1, 32'h3FE, 0);
    op(0, 2'd0, 1, 32'h3FF, 0);
    op(0, 2'd0, 0, 32'h3FD, 0);
    send(0, 2'd2, 0, 32'h8, 0, a0);
    check("busy_ready", 32'(req_ready), 0);
    send(0, 2'd2, 0, 32'h0, 0, a1);
    check("b2b_gap", a1 - a0, WC + 2);
    drain();
    op(1, 2'd2, 0, 32'h10, 32'hCAFEF00D);
    send(1, 2'd2, 0, 32'h10, 32'h12345678, a0);
    reset = 1;
    @(negedge clk);
    sb.delete();
    reset_model();
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    reset = 0;
    wait_ready(n);
    check("abort_ready_timeout", 32'(n < 1000), 1);
    repeat (WC + 3) @(negedge clk);
    op(0, 2'd2, 0, 32'h10, 0);
    for (int i = 0; i < 16; i++) op(1, 2'd2, 0, 32'(i * 4), 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 9) == 0 ? 32'($urandom_range(32'h3F8, 32'h407)) : 32'($urandom_range(0, 63));
      send(1'($urandom), $urandom_range(0, 5) == 0 ? 2'd3 : 2'($urandom_range(0, 2)), 1'($urandom), a, $urandom, a0);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dlx_data_mem.md
Name: dlx_data_mem

Overview:
Parametrised, byte-addressed data memory for the SDLX load/store stage. It supports byte, halfword and word accesses, with sign or zero extension on loads. Requests use a valid/ready handshake, with a configurable number of wait states so that slower memories can be modelled. The block reports misaligned and out-of-range accesses. An optional sequencer clears the whole array after reset.

Parameters:
ADDR_W, 32, width of the byte address.
DEPTH, 256, number of 32-bit words. Any value from 1 to 2^(ADDR_W-2).
WAIT_CYCLES, 0, extra cycles between request acceptance and response. Range 0..255.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data; sub-word data is taken from the low bits.
rsp_valid  output  1  one-cycle pulse marking the response.
rsp_rdata  output  32  load result. 0 for stores and for errors.
rsp_err  output  1  access rejected; valid only while rsp_valid = 1.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State goes to CLEAR, or to IDLE when DMEM_CLEAR_EN is not defined.
  - Reset has priority over every other event. A request accepted but not yet answered is aborted: no write, no response.
- States: CLEAR, IDLE, BUSY.
  - CLEAR: writes zero to word clr_idx and increments it once per cycle, covering 0..DEPTH-1. Goes to IDLE on the cycle after word DEPTH-1 is written. req_ready=0 throughout, so it is low for exactly DEPTH cycles after reset deasserts.
  - IDLE: req_ready=1. On a rising edge with req_valid and req_ready both 1, capture we/size/signed/addr/wdata, load wait_cnt=WAIT_CYCLES and go to BUSY.
  - BUSY: req_ready=0. While wait_cnt is non-zero, decrement it. On the edge where wait_cnt=0, perform the access, register the response, and return to IDLE.
- Timing:
  - A request accepted at edge N produces rsp_valid=1 for the single cycle following edge N+WAIT_CYCLES+1.
  - The next request can be accepted at edge N+WAIT_CYCLES+2 at the earliest.
  - rsp_valid is 0 in every other cycle.
- Addressing: little-endian; word index = addr[ADDR_W-1:2]; byte lane = addr[1:0] (lane 0 = bits 7:0).
- Error conditions (rsp_err=1, no write, rsp_rdata=0):
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - word index ≥ DEPTH.
- Stores:
  - byte writes lane addr[1:0] with wdata[7:0];
  - halfword writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all four lanes;
  - untouched lanes keep their contents.
- Loads:
  - the selected byte or halfword is placed in the low bits, then extended according to req_signed;
  - a word load returns the word unchanged and ignores req_signed.
- Inputs are sampled only at the acceptance edge; changes to them while BUSY are ignored.
- With DMEM_CLEAR_EN not defined, memory contents are undefined until written.

Optional Feature:
DMEM_CLEAR_EN.
- Defined: reset enters CLEAR, as described above.
- Not defined: no CLEAR state. The block enters IDLE on the first edge after reset deasserts, and memory contents are preserved across reset.

Test Plan:
- DMEM_CLEAR_EN defined, DEPTH=256. Hold reset high for 2 cycles, then release → req_ready=0 for exactly 256 cycles, then 1. LW at 0x40 → rsp_rdata=0x00000000, rsp_err=0.
- SW 0x8 with data 0xDEADBEEF, then LW 0x8 → 0xDEADBEEF, rsp_err=0. Both responses are single-cycle pulses.
- After the previous test, SB 0x9 with data 0x80. Then:
  - LB signed 0x9 → 0xFFFFFF80;
  - LBU 0x9 → 0x00000080;
  - LW 0x8 → 0xDEAD80EF;
  - LH signed 0xA → 0xFFFFDEAD.
- LH at 0x3 → rsp_err=1, rdata=0. SW at 0x400 (word 256) → rsp_err=1. A following LW 0x0 → unchanged value. size=11 → rsp_err=1.
- WAIT_CYCLES=3, request accepted at edge N → req_ready=0 until rsp_valid, rsp_valid high only after edge N+4. A back-to-back request is accepted at edge N+5.
- SW 0x10 with data 0x12345678 is accepted; reset is asserted before the response is due (DMEM_CLEAR_EN not defined) → no rsp_valid. A later LW 0x10 returns the prior value, not 0x12345678.
